cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, CPU/memory byte-address width.
  DATA_W, 32, word width.
  LINES, 16, number of direct-mapped one-word lines; power of two.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk  in  1  single clock; all state updates on rising edge.
  reset  in  1  synchronous, active-high reset.
  cpu_req  in  1  access request from the MEM stage.
  cpu_we  in  1  1 ⇒ write, 0 ⇒ read.
  cpu_addr  in  ADDR_W  byte address, word-aligned.
  cpu_wdata  in  DATA_W  store data.
  cpu_rdata  out  DATA_W  load data; valid when cpu_req & ~cpu_we & cache_ready.
  cache_ready  out  1  1 ⇒ current access completes this cycle, or no access is pending; drives the stall logic.
  mem_req  out  1  memory transaction request.
  mem_we  out  1  memory write enable.
  mem_addr  out  ADDR_W  memory word address.
  mem_wdata  out  DATA_W  memory write data.
  mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
  mem_ready  in  1  memory completes the transaction this cycle.

Function
REQ-003 Address split SHALL be: index = cpu_addr[log2(LINES)+1:2], tag = cpu_addr[ADDR_W-1:log2(LINES)+2], and bits [1:0] ignored.
REQ-004 Hit SHALL be defined as valid[index] & (tag_store[index] == tag), evaluated combinationally.
REQ-005 FSM SHALL have three states: IDLE, FILL, WRITE_THRU.
REQ-006 IDLE, no request: cache_ready=1, mem_req=0, and the state SHALL stay IDLE.
REQ-007 IDLE, read hit: cache_ready=1 and cpu_rdata=data_store[index] in the same cycle (zero-cycle latency), with no memory access.
REQ-008 IDLE, read miss: cache_ready=0, and at the next edge the FSM SHALL go to FILL, latching mem_addr={cpu_addr[ADDR_W-1:2],2'b00} and mem_we=0.
REQ-009 IDLE, any write: cache_ready=0, and at the next edge the FSM SHALL go to WRITE_THRU, latching mem_addr, mem_wdata=cpu_wdata and mem_we=1.
REQ-010 In FILL and WRITE_THRU, mem_req SHALL be 1, and mem_addr, mem_we and mem_wdata SHALL be held stable until mem_ready is sampled 1.
REQ-011 FILL with mem_ready=1: cache_ready=1 and cpu_rdata=mem_rdata (bypass); at the edge the line SHALL be written (valid=1, tag, data) and the FSM SHALL return to IDLE.
REQ-012 WRITE_THRU with mem_ready=1: cache_ready=1; if the address hits, the line data SHALL be updated (write-through); a write miss SHALL NOT allocate a line; the FSM SHALL return to IDLE.
REQ-013 In FILL or WRITE_THRU with mem_ready=0, cache_ready SHALL be 0; the wait SHALL be unbounded.
REQ-014 The CPU SHALL hold cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cache_ready=0; the block SHALL use its latched copies for the memory transaction.
REQ-015 If cpu_req drops mid-transaction, the memory transaction SHALL still complete and update the line per REQ-011/012; no abort.
REQ-016 mem_ready while IDLE SHALL be ignored.
REQ-017 A conflicting line (same index, different tag) SHALL be overwritten on fill; no replacement policy.

Reset
REQ-018 While reset=1: state←IDLE and all valid bits←0 at the edge; mem_req=0 and cache_ready=1 are forced combinationally; mem_addr, mem_wdata, mem_we and cpu_rdata←0.
REQ-019 Reset mid-FILL or mid-WRITE_THRU SHALL abandon the transaction (mem_req=0 after the edge) and SHALL NOT write any line.
REQ-020 Tag and data arrays SHALL NOT require reset; only the valid bits are reset.

Structure
REQ-021 Shared package cache_pkg SHALL hold the FSM state encoding, LINES, INDEX_W and TAG_W.
REQ-022 Tag/valid/data storage SHALL be one sub-module, cache_array: 1 combinational read port, 1 write port, synchronous valid clear.

Verification
REQ-023 After reset, read 0x0000_0040, mem_ready after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x40, cache_ready 0 for 3 cycles then 1, cpu_rdata=0xDEADBEEF; repeat read -> same-cycle hit, mem_req stays 0.
REQ-024 Read 0x40 then read 0x80 (same index 0, different tag) then read 0x40 -> three misses, three FILL transactions.
REQ-025 Write 0x12345678 to cached 0x40 -> one memory write, mem_wdata=0x12345678; next read of 0x40 hits and returns 0x12345678.
REQ-026 Write to uncached 0x100 -> memory write issued; next read of 0x100 misses (no allocate).
REQ-027 Assert reset during FILL for 0x40 -> mem_req=0 the cycle after; next read of 0x40 misses.
REQ-028 mem_ready=1 for 5 cycles in IDLE with cpu_req=0 -> state stays IDLE, cache_ready=1, mem_req=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-through cache.
package cache_pkg;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int LINES          = 16;
    localparam int INDEX_W        = $clog2(LINES);
    localparam int TAG_W          = DEFAULT_ADDR_W - INDEX_W - 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_FILL       = 2'd1;
    localparam state_t ST_WRITE_THRU = 2'd2;
endpackage

// File: rtl/cache_array.sv
// Tag/valid/data storage: one combinational read port, one write port,
// valid bits cleared synchronously on reset; tag and data are never reset.
module cache_array #(
    parameter int LINES   = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid_vec;

    // One flop per line so each valid bit has a single driver.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        logic line_valid_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                line_valid_reg <= 1'b0;
            end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
                line_valid_reg <= 1'b1;
            end
        end

        assign valid_vec[gi] = line_valid_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_vec[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-line cache: zero-latency read hits, read-miss fill
// with bypass, write-through with no write-allocate, single outstanding access.
module cache_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = cache_pkg::LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cache_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import cache_pkg::state_t;
    import cache_pkg::ST_IDLE;
    import cache_pkg::ST_FILL;
    import cache_pkg::ST_WRITE_THRU;

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_we_reg;

    logic [ADDR_W-1:0]  lookup_addr;
    logic [INDEX_W-1:0] lookup_index;
    logic [TAG_W-1:0]   lookup_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [DATA_W-1:0]  rd_data;
    logic               hit;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               start_txn;
    logic               unused_byte_bits;

    // Outside IDLE the CPU may drop or change its request, so look up with the latched address.
    assign lookup_addr      = (state_reg == ST_IDLE) ? cpu_addr : mem_addr_reg;
    assign lookup_index     = lookup_addr[INDEX_W+1:2];
    assign lookup_tag       = lookup_addr[ADDR_W-1:INDEX_W+2];
    assign unused_byte_bits = ^lookup_addr[1:0];
    assign hit              = rd_valid && (rd_tag == lookup_tag);

    cache_array #(
        .LINES  (LINES),
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_index(lookup_index),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_index(lookup_index),
        .wr_tag  (lookup_tag),
        .wr_data (wr_data)
    );

    always_comb begin
        state_next  = state_reg;
        cache_ready = 1'b1;
        wr_en       = 1'b0;
        wr_data     = mem_rdata;
        case (state_reg)
            ST_IDLE: begin
                if (cpu_req && cpu_we) begin
                    cache_ready = 1'b0;
                    state_next  = ST_WRITE_THRU;
                end else if (cpu_req && !hit) begin
                    cache_ready = 1'b0;
                    state_next  = ST_FILL;
                end
            end
            ST_FILL: begin
                cache_ready = mem_ready;
                if (mem_ready) begin
                    wr_en      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE_THRU: begin
                cache_ready = mem_ready;
                if (mem_ready) begin
                    wr_en      = hit;
                    wr_data    = mem_wdata_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Reset abandons any transaction in flight without touching the arrays.
        if (reset) begin
            cache_ready = 1'b1;
            wr_en       = 1'b0;
        end
    end

    assign start_txn = (state_reg == ST_IDLE) && (state_next != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_txn) begin
                mem_addr_reg <= {cpu_addr[ADDR_W-1:2], 2'b00};
                mem_we_reg   <= cpu_we;
                if (cpu_we) begin
                    mem_wdata_reg <= cpu_wdata;
                end
            end
        end
    end

    assign mem_req   = (state_reg != ST_IDLE) && !reset;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_rdata = reset ? '0 : ((state_reg == ST_FILL) ? mem_rdata : rd_data);
endmodule
